// File: rtl/axil_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite memory slave.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axil_mem_ram.sv
// Word-organised storage: byte-enabled write port, registered read port (read-before-write).
module axil_mem_ram #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 256,
    localparam int IDXW       = $clog2(DEPTH),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [IDXW-1:0]       waddr_i,
    input  logic [STRB_W-1:0]     wstrb_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [IDXW-1:0]       raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_mem_slave.sv
// AXI4-Lite slave in front of axil_mem_ram, with independent write and read FSMs.
// Optional: define AXIL_MEM_RANGE_CHECK_EN to answer out-of-range addresses with SLVERR.
module axil_mem_slave
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output w_state_e                w_state_o,
    output r_state_e                r_state_o
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int LSB     = $clog2(STRB_W);
    localparam int IDXW    = $clog2(DEPTH);
    localparam int TOP_BIT = LSB + IDXW;

    // Handshakes: a transfer happens on an edge where VALID && READY; VALID never waits on READY,
    // READY depends only on local state, and payloads are held stable while VALID && !READY.
    logic aw_hs, w_hs, ar_hs;
    logic aw_oor, ar_oor;
    logic [IDXW-1:0] aw_idx, ar_idx;
    logic unused_addr_bits;

    assign aw_idx = AWADDR[LSB +: IDXW];
    assign ar_idx = ARADDR[LSB +: IDXW];
    assign unused_addr_bits = ^{AWADDR, ARADDR};

`ifdef AXIL_MEM_RANGE_CHECK_EN
    if (ADDR_WIDTH > TOP_BIT) begin : g_range
        assign aw_oor = |AWADDR[ADDR_WIDTH-1:TOP_BIT];
        assign ar_oor = |ARADDR[ADDR_WIDTH-1:TOP_BIT];
    end else begin : g_no_range
        assign aw_oor = 1'b0;
        assign ar_oor = 1'b0;
    end
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // ---------------- write path ----------------
    w_state_e              w_state_q, w_state_d;
    logic                  aw_full_q, aw_full_d, aw_oor_q, aw_oor_d;
    logic [IDXW-1:0]       aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  mem_we, cur_oor;
    logic [IDXW-1:0]       mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [STRB_W-1:0]     mem_wstrb;

    assign AWREADY = !aw_full_q && (w_state_q == W_IDLE);
    assign WREADY  = !w_full_q && (w_state_q == W_IDLE);
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign BVALID  = (w_state_q == W_RESP);
    assign BRESP   = bresp_q;

    always_comb begin
        w_state_d = w_state_q;
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        aw_oor_d  = aw_oor_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        // A held payload wins; otherwise take the one handshaking this edge.
        mem_widx  = aw_full_q ? aw_idx_q : aw_idx;
        cur_oor   = aw_full_q ? aw_oor_q : aw_oor;
        mem_wdata = w_full_q ? wdata_q : WDATA;
        mem_wstrb = w_full_q ? wstrb_q : WSTRB;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_full_d = 1'b1;
                    aw_idx_d  = aw_idx;
                    aw_oor_d  = aw_oor;
                end
                if (w_hs) begin
                    w_full_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
                if ((aw_full_q || aw_hs) && (w_full_q || w_hs)) begin
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    mem_we    = !cur_oor;
                    bresp_d   = cur_oor ? RESP_SLVERR : RESP_OKAY;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            aw_oor_q  <= 1'b0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            aw_oor_q  <= aw_oor_d;
            w_full_q  <= w_full_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    // ---------------- read path ----------------
    r_state_e              r_state_q, r_state_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rd_oor_q, rd_oor_d;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign ARREADY = (r_state_q == R_IDLE);
    assign ar_hs   = ARVALID && ARREADY;
    assign RVALID  = (r_state_q == R_DATA);
    assign RRESP   = rresp_q;
    assign RDATA   = rd_oor_q ? '0 : ram_rdata;

    always_comb begin
        r_state_d = r_state_q;
        rresp_d   = rresp_q;
        rd_oor_d  = rd_oor_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rresp_d   = ar_oor ? RESP_SLVERR : RESP_OKAY;
                    rd_oor_d  = ar_oor;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            rresp_q   <= RESP_OKAY;
            rd_oor_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rresp_q   <= rresp_d;
            rd_oor_q  <= rd_oor_d;
        end
    end

    assign w_state_o = w_state_q;
    assign r_state_o = r_state_q;

    axil_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .we_i    (mem_we && ARESETn),
        .waddr_i (mem_widx),
        .wstrb_i (mem_wstrb),
        .wdata_i (mem_wdata),
        .re_i    (ar_hs && ARESETn),
        .raddr_i (ar_idx),
        .rdata_o (ram_rdata)
    );

endmodule

// File: doc/axil_mem_slave.md
AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of AWADDR/ARADDR.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 32 and 64.
REQ-003 SHALL have parameter DEPTH, default 256, number of DATA_WIDTH words; power of two, at least 2.
REQ-004 SHALL have port ACLK  in  1  clock; all logic on the rising edge.
REQ-005 SHALL have port ARESETn  in  1  synchronous, active-low reset.
REQ-006 SHALL have port AWADDR  in  ADDR_WIDTH  write byte address.
REQ-007 SHALL have port AWVALID / AWREADY  in / out  1  write-address handshake.
REQ-008 SHALL have port WDATA  in  DATA_WIDTH  write data.
REQ-009 SHALL have port WSTRB  in  DATA_WIDTH/8  byte-lane write enables.
REQ-010 SHALL have port WVALID / WREADY  in / out  1  write-data handshake.
REQ-011 SHALL have port BRESP  out  2  write response.
REQ-012 SHALL have port BVALID / BREADY  out / in  1  write-response handshake.
REQ-013 SHALL have port ARADDR  in  ADDR_WIDTH  read byte address.
REQ-014 SHALL have port ARVALID / ARREADY  in / out  1  read-address handshake.
REQ-015 SHALL have port RDATA  out  DATA_WIDTH  read data.
REQ-016 SHALL have port RRESP  out  2  read response.
REQ-017 SHALL have port RVALID / RREADY  out / in  1  read-data handshake.

Function
REQ-018 SHALL form the word index as addr[LSB +: log2(DEPTH)], with LSB = log2(DATA_WIDTH/8); low LSB bits are ignored.
REQ-019 SHALL run a write FSM with states W_IDLE and W_RESP, plus independent AW and W holding registers (aw_full, w_full).
REQ-020 SHALL drive AWREADY = !aw_full && state==W_IDLE and WREADY = !w_full && state==W_IDLE, with no dependency on the other channel's VALID.
REQ-021 SHALL commit the write on the edge where both an address and data are available (held or handshaking that edge), updating only the lanes whose WSTRB bit is 1.
REQ-022 SHALL, on that commit edge, clear both holding registers, set BVALID=1, and enter W_RESP, so BVALID is seen one cycle after the later handshake.
REQ-023 SHALL hold BVALID and BRESP stable until BREADY, then return to W_IDLE on that edge.
REQ-024 SHALL run a read FSM with states R_IDLE and R_DATA, with ARREADY = (state==R_IDLE).
REQ-025 SHALL, on an AR handshake, register RDATA/RRESP, set RVALID=1 the next cycle, and hold RDATA/RRESP stable until RREADY, then return to R_IDLE.
REQ-026 SHALL handle simultaneous write commit and read capture of the same word by returning the pre-write data.
REQ-027 SHALL keep the read and write paths fully independent; concurrent read and write in the same cycle are both accepted.
REQ-028 SHALL return OKAY (2'b00) for all responses, except as defined under Configuration.

Reset
REQ-029 SHALL, while ARESETn=0 at an edge, force: both FSMs to idle, aw_full=w_full=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0; memory contents are not cleared.
REQ-030 SHALL abandon any in-flight transaction when reset is asserted mid-operation, performing no memory write for it; AWREADY/WREADY/ARREADY read 1 in the first cycle after release.

Configuration
REQ-031 SHALL, with macro AXIL_MEM_RANGE_CHECK_EN defined, give any address >= DEPTH*(DATA_WIDTH/8) response SLVERR (2'b10), perform no write, and return RDATA=0.
REQ-032 SHALL, without AXIL_MEM_RANGE_CHECK_EN, ignore upper address bits so the index wraps modulo DEPTH, and always respond OKAY.

Structure
REQ-033 SHALL place the RESP_OKAY/RESP_SLVERR constants and the write/read FSM state typedefs in the shared package axil_pkg.
REQ-034 SHALL implement the storage as sub-module axil_mem_ram: single clock, byte-enabled write port, registered read port.

Verification
REQ-035 Bench SHALL drive AW=0x10 and W=0xDEADBEEF with WSTRB=0xF in the same cycle -> BVALID the next cycle with BRESP=00; a read of 0x10 -> RDATA=0xDEADBEEF, RRESP=00.
REQ-036 Bench SHALL send W three cycles before AW=0x20 -> WREADY drops after the W handshake and the write commits on the AW handshake edge; a later read of 0x20 returns the data.
REQ-037 Bench SHALL write 0x11223344 to 0x30, then 0xAABBCCDD with WSTRB=0x2 -> a read of 0x30 returns 0x1122CC44.
REQ-038 Bench SHALL hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID/RVALID and their data/resp stay stable, AWREADY=WREADY=ARREADY=0, and the response completes on the cycle ready rises.
REQ-039 Bench SHALL, with the macro defined, issue AW=0x400 (DEPTH=256) -> BRESP=10 and memory unchanged; a read of 0x400 -> RRESP=10, RDATA=0. Without the macro, the read of 0x400 returns word 0.
REQ-040 Bench SHALL assert ARESETn=0 with AW held but W pending -> after release, a new W produces no write to the old address and BVALID stays 0.
